// File: rtl/comparator2bit_pkg.sv
// Shared types, constants and the golden comparison rule for the
// 2-bit comparator response checker.
package comparator2bit_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD   = 3'd1,
        ST_SETTLE = 3'd2,
        ST_CHECK  = 3'd3,
        ST_DONE   = 3'd4
    } state_e;

    localparam int NUM_VECTORS = 16;

    // Returns {gt, eq, lt} for unsigned 2-bit operands.
    function automatic logic [2:0] cmp2_expected(input logic [1:0] a, input logic [1:0] b);
        logic [2:0] res;
        res[2] = (a > b);
        res[1] = (a == b);
        res[0] = (a < b);
        return res;
    endfunction

endpackage

// File: rtl/comparator2bit_golden_model.sv
// Combinational reference response for the vector currently driven
// by the checker's stimulus registers.
module comparator2bit_golden_model
    import comparator2bit_pkg::*;
(
    input  logic [1:0] a_i,
    input  logic [1:0] b_i,
    output logic [2:0] exp_o
);

    assign exp_o = cmp2_expected(a_i, b_i);

endmodule

// File: rtl/comparator2bit_response_checker.sv
// Closed-loop checker: sweeps all 16 input vectors through an external
// 2-bit comparator and compares each settled response with the golden model.
module comparator2bit_response_checker
    import comparator2bit_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    output logic       A1,
    output logic       A0,
    output logic       B1,
    output logic       B0,
    input  logic       AgtB,
    input  logic       AeqB,
    input  logic       AltB,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [4:0] err_count,
    output logic       first_fail_valid,
    output logic [3:0] first_fail_idx
);

    localparam logic [3:0] SETTLE_LD = 4'(SETTLE_CYCLES);
    localparam logic [3:0] LAST_IDX  = 4'(NUM_VECTORS - 1);

    state_e     state_q, state_d;
    logic [3:0] idx_q, idx_d;
    logic [3:0] cnt_q, cnt_d;
    logic [4:0] err_q, err_d;
    logic       ffv_q, ffv_d;
    logic [3:0] ffi_q, ffi_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;
    logic       pass_q, pass_d;

    logic [2:0] exp_s;
    logic [2:0] resp_s;
    logic       fail_s;

    // The index register doubles as the stimulus register, so the golden
    // model always sees exactly what the comparator sees.
    comparator2bit_golden_model u_golden (
        .a_i   (idx_q[3:2]),
        .b_i   (idx_q[1:0]),
        .exp_o (exp_s)
    );

    assign resp_s = {AgtB, AeqB, AltB};
    // exp_s is one-hot, so any non-one-hot response mismatches here.
    assign fail_s = (resp_s != exp_s);

    // Next-state and datapath update for the sweep sequencer.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        ffv_d   = ffv_q;
        ffi_d   = ffi_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_LOAD;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_LOAD: begin
                idx_d   = 4'd0;
                cnt_d   = SETTLE_LD;
                err_d   = 5'd0;
                ffv_d   = 1'b0;
                ffi_d   = 4'd0;
                state_d = ST_SETTLE;
            end
            ST_SETTLE: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q <= 4'd1) begin
                    state_d = ST_CHECK;
                end else begin
                    state_d = ST_SETTLE;
                end
            end
            ST_CHECK: begin
                if (fail_s) begin
                    err_d = err_q + 5'd1;
                    if (!ffv_q) begin
                        ffv_d = 1'b1;
                        ffi_d = idx_q;
                    end else begin
                        ffv_d = ffv_q;
                    end
                end else begin
                    err_d = err_q;
                end
                if (idx_q == LAST_IDX) begin
                    state_d = ST_DONE;
                end else begin
                    idx_d   = idx_q + 4'd1;
                    cnt_d   = SETTLE_LD;
                    state_d = ST_SETTLE;
                end
            end
            ST_DONE: begin
                if (start) begin
                    state_d = ST_LOAD;
                end else begin
                    state_d = ST_DONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Status flags lag the state by one edge so they line up with the
    // stimulus and result registers written on the same edge.
    always_comb begin
        busy_d = (state_q == ST_LOAD) || (state_q == ST_SETTLE) || (state_q == ST_CHECK);
        done_d = (state_q == ST_DONE);
        pass_d = (state_q == ST_DONE) && (err_q == 5'd0);
    end

    // State and result registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            idx_q   <= 4'd0;
            cnt_q   <= 4'd0;
            err_q   <= 5'd0;
            ffv_q   <= 1'b0;
            ffi_q   <= 4'd0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            ffv_q   <= ffv_d;
            ffi_q   <= ffi_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            pass_q  <= pass_d;
        end
    end

    assign A1               = idx_q[3];
    assign A0               = idx_q[2];
    assign B1               = idx_q[1];
    assign B0               = idx_q[0];
    assign busy             = busy_q;
    assign done             = done_q;
    assign pass             = pass_q;
    assign err_count        = err_q;
    assign first_fail_valid = ffv_q;
    assign first_fail_idx   = ffi_q;

endmodule

// File: doc/comparator2bit_response_checker.md
# comparator2bit_response_checker

Hardware self-checking harness for the 2-bit magnitude comparator. It drives all 16 input combinations into the comparator, samples AgtB/AeqB/AltB after a programmable settle window, and checks each sample against a golden model. It reports pass/fail, an error count and the first failing vector index. It sits beside the comparator in on-board bring-up builds and replaces the open-loop stimulus bench with a closed-loop checker.

## Interface
- SETTLE_CYCLES, 2, clock cycles each vector is held before the DUT outputs are sampled on the next edge; legal range 1..15.
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  one-cycle or level request; only honoured in IDLE or DONE.
- A1, A0, B1, B0  output  1 each  registered stimulus to the comparator.
- AgtB, AeqB, AltB  input  1 each  comparator responses.
- busy  output  1  run in progress.
- done  output  1  run finished; held until the next start.
- pass  output  1  valid when done=1; 1 when err_count==0.
- err_count  output  5  number of failing vectors, 0..16.
- first_fail_valid  output  1  at least one vector failed in this run.
- first_fail_idx  output  4  index of the first failing vector.

## Operation
- Vector index i runs from 0 to 15 with A1=i[3], A0=i[2], B1=i[1], B0=i[0]. A={A1,A0} and B={B1,B0} are unsigned.
- Expected response: AgtB=(A>B), AeqB=(A==B), AltB=(A<B).
- A vector fails if any of the three responses differs from the expected value. A non-one-hot response always fails.
- States:
  - IDLE: outputs are at their reset values. start → LOAD.
  - LOAD: drives vector 0, clears err_count, first_fail_valid, first_fail_idx and done, and loads the settle counter with SETTLE_CYCLES. → SETTLE.
  - SETTLE: decrements the counter each cycle. When the counter reaches 0 → CHECK.
  - CHECK: samples and compares the responses. On a fail it increments err_count; if first_fail_valid is 0 it also sets first_fail_idx=i and first_fail_valid=1. If i<15 it drives vector i+1, reloads the counter and → SETTLE; if i==15 → DONE.
  - DONE: busy=0, done=1, pass=(err_count==0). start → LOAD, which starts a fresh run.
- busy=1 in LOAD, SETTLE and CHECK.
- start is ignored while busy=1.
- Reset values of all outputs are 0: A1, A0, B1, B0, busy, done, pass, err_count, first_fail_valid, first_fail_idx.
- Reset asserted mid-run returns the block to IDLE immediately. Partial results are discarded.

## Timing
- Edge k samples start=1 in IDLE or DONE. The LOAD output values (vector 0 and cleared status) are visible after edge k+1.
- Each vector is stable for SETTLE_CYCLES+1 cycles before its sampling edge. The next vector appears on the same edge that samples the current one.
- Vector i is sampled at edge k+1+(i+1)(SETTLE_CYCLES+1).
- done rises, and busy falls, on the edge after the vector-15 sample.
- Total run length: start edge to done visible is 2+16(SETTLE_CYCLES+1) cycles. This is 50 cycles at the default.
- err_count saturation cannot occur because it tops out at 16, which fits in 5 bits.
- DUT inputs are treated as synchronous. The DUT's combinational delay must be less than SETTLE_CYCLES+1 clock periods.

## Structure
- Package comparator2bit_pkg contains:
  - the state enum (IDLE, LOAD, SETTLE, CHECK, DONE);
  - the constant NUM_VECTORS=16;
  - the function cmp2_expected(a[1:0], b[1:0]), which returns {gt,eq,lt}.
- Sub-module comparator2bit_golden_model: a combinational reference that wraps cmp2_expected. It is instantiated once and fed from the stimulus registers.
- The checker top level holds the FSM, the vector index counter, the settle counter and the status registers.

## Test plan
- Correct comparator, SETTLE_CYCLES=2, start pulse → done=1 exactly 50 cycles after the start edge; pass=1, err_count=0, first_fail_valid=0.
- DUT with AeqB stuck at 0 → vectors 0, 5, 10 and 15 fail; err_count=4, first_fail_idx=0, pass=0.
- DUT with AgtB and AltB swapped → all 12 unequal vectors fail; err_count=12, first_fail_idx=1.
- Observe vector 6 → A1=0, A0=1, B1=1, B0=0 held 3 cycles; expected response AltB=1.
- start held high throughout the run → no restart while busy. From DONE, a second start clears the status and repeats the identical 50-cycle run.
- rst_n pulled low while vector 7 is driven → all outputs 0 asynchronously and state IDLE. After release, the block waits for start.
